// File: rtl/arbitro_mem_dados.sv
// Two-port round-robin arbiter/sequencer in front of a single-port 64x32 data memory.
// Optional macro MEM_ARB_CONTADOR_EN adds saturating ack/error counters.
module arbitro_mem_dados #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] posicao,
  output logic [DATA_W-1:0] dados,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] saidaDados,
`ifdef MEM_ARB_CONTADOR_EN
  output logic [15:0]       cont0,
  output logic [15:0]       cont1,
  output logic [15:0]       cont_err,
`endif
  output logic              ocupado
);

  typedef enum logic [1:0] {StOcioso, StAcesso, StResp} estado_t;

  estado_t             r_estado, w_estado_d;
  logic                r_ultimo, r_sel, r_we, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata0, r_rdata1;
  logic                w_grant, w_sel_d, w_fora0, w_fora1;
  logic [DATA_W-1:0]   w_captura;

  // Full-width compare: high address bits must never alias into the array.
  assign w_fora0 = (addr0 >= ADDR_W'(DEPTH));
  assign w_fora1 = (addr1 >= ADDR_W'(DEPTH));

  always_comb begin
    w_estado_d = r_estado;
    w_grant    = 1'b0;
    w_sel_d    = r_sel;
    case (r_estado)
      StOcioso: begin
        if (req0 || req1) begin
          w_grant    = 1'b1;
          w_sel_d    = (req0 && req1) ? ~r_ultimo : req1;
          w_estado_d = StAcesso;
        end
      end
      StAcesso: w_estado_d = StResp;
      StResp:   w_estado_d = StOcioso;
      default:  w_estado_d = StOcioso;
    endcase
  end

  assign w_captura = r_err ? '0 : saidaDados;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= StOcioso;
      r_ultimo <= 1'b1;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_estado <= w_estado_d;
      if (w_grant) begin
        r_sel    <= w_sel_d;
        r_ultimo <= w_sel_d;
        r_we     <= w_sel_d ? we1 : we0;
        r_addr   <= w_sel_d ? addr1 : addr0;
        r_wdata  <= w_sel_d ? wdata1 : wdata0;
        r_err    <= w_sel_d ? w_fora1 : w_fora0;
      end
      // In-range writes leave the requester's read register untouched.
      if (r_estado == StAcesso && (r_err || !r_we)) begin
        if (r_sel) r_rdata1 <= w_captura;
        else       r_rdata0 <= w_captura;
      end
    end
  end

`ifdef MEM_ARB_CONTADOR_EN
  logic [15:0] r_cont0, r_cont1, r_cont_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cont0    <= '0;
      r_cont1    <= '0;
      r_cont_err <= '0;
    end else if (r_estado == StResp) begin
      if (!r_sel && r_cont0 != 16'hFFFF) r_cont0 <= r_cont0 + 16'd1;
      if (r_sel && r_cont1 != 16'hFFFF)  r_cont1 <= r_cont1 + 16'd1;
      if (r_err && r_cont_err != 16'hFFFF) r_cont_err <= r_cont_err + 16'd1;
    end
  end

  assign cont0    = r_cont0;
  assign cont1    = r_cont1;
  assign cont_err = r_cont_err;
`endif

  assign posicao  = r_addr;
  assign dados    = r_wdata;
  assign memWrite = (r_estado == StAcesso) && r_we && !r_err;
  assign memRead  = (r_estado == StAcesso) && !r_we && !r_err;
  assign ack0     = (r_estado == StResp) && !r_sel;
  assign ack1     = (r_estado == StResp) && r_sel;
  assign err0     = ack0 && r_err;
  assign err1     = ack1 && r_err;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign ocupado  = (r_estado != StOcioso);

endmodule

// File: tb/tb_arbitro_mem_dados.sv
// Self-checking bench for arbitro_mem_dados: directed cases plus random request batches
// scored against a transaction-level model (service order, memory contents, counters).
module tb_arbitro_mem_dados;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1, posicao, dados, saidaDados;
  logic        memWrite, memRead, ocupado;
`ifdef MEM_ARB_CONTADOR_EN
  logic [15:0] cont0, cont1, cont_err;
`endif

  always #5 clk = ~clk;

  arbitro_mem_dados #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .posicao(posicao), .dados(dados), .memWrite(memWrite), .memRead(memRead),
    .saidaDados(saidaDados),
`ifdef MEM_ARB_CONTADOR_EN
    .cont0(cont0), .cont1(cont1), .cont_err(cont_err),
`endif
    .ocupado(ocupado)
  );

  // The physical memory; wraps on the low 6 bits so stray out-of-range strobes show up.
  logic [31:0] mem [64];
  assign saidaDados = mem[posicao[5:0]];
  always @(posedge clk) if (memWrite) mem[posicao[5:0]] <= dados;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        q0[$], q1[$];
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rd [2];
  int          ref_last;
  int          ref_c0, ref_c1, ref_ce;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) == 0) t.addr = $urandom | 32'h0000_0040;
    else t.addr = 32'($urandom_range(0, 63));
    t.data = $urandom;
    return t;
  endfunction

  task automatic drive(input int p, input logic r, input txn_t t);
    if (p == 0) begin req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.data; end
    else        begin req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.data; end
  endtask

  task automatic model_reset();
    ref_last = 1;
    ref_rd[0] = '0; ref_rd[1] = '0;
    ref_c0 = 0; ref_c1 = 0; ref_ce = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk1("idle_ocupado", ocupado, 1'b0);
      chk1("idle_ack", ack0 | ack1, 1'b0);
      chk1("idle_memWrite", memWrite, 1'b0);
    end
  endtask

  // Requesters re-request immediately after each ack, so at every grant every port with
  // work left is asking; the order follows from the round-robin rule alone.
  task automatic run_batch();
    int   ord[$];
    txn_t ot[$];
    txn_t a[$], b[$];
    int   last, p;
    a = q0; b = q1; last = ref_last;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) p = 1 - last;
      else if (a.size() > 0) p = 0;
      else p = 1;
      ord.push_back(p);
      if (p == 0) ot.push_back(a.pop_front());
      else        ot.push_back(b.pop_front());
      last = p;
    end
    if (q0.size() > 0) drive(0, 1'b1, q0[0]);
    if (q1.size() > 0) drive(1, 1'b1, q1[0]);
    for (int k = 1; k <= 3 * ord.size(); k++) begin
      int   i, ph, sp;
      logic inr;
      txn_t t;
      @(posedge clk); #1;
      i = (k - 1) / 3; ph = (k - 1) % 3; sp = ord[i]; t = ot[i];
      inr = (t.addr < 32'd64);
      if (ph == 0) begin
        chk1("acc_ocupado", ocupado, 1'b1);
        chk("acc_posicao", posicao, t.addr);
        chk("acc_dados", dados, t.data);
        chk1("acc_memWrite", memWrite, t.we && inr);
        chk1("acc_memRead", memRead, !t.we && inr);
        chk1("acc_ack", ack0 | ack1, 1'b0);
        if (!inr) ref_rd[sp] = '0;
        else if (!t.we) ref_rd[sp] = ref_mem[t.addr[5:0]];
        else ref_mem[t.addr[5:0]] = t.data;
      end else if (ph == 1) begin
        chk1("resp_ack0", ack0, sp == 0);
        chk1("resp_ack1", ack1, sp == 1);
        chk1("resp_err", (sp == 0) ? err0 : err1, !inr);
        chk1("resp_err_other", (sp == 0) ? err1 : err0, 1'b0);
        chk("resp_rdata", (sp == 0) ? rdata0 : rdata1, ref_rd[sp]);
        chk1("resp_strobes", memWrite | memRead, 1'b0);
        if (sp == 0 && ref_c0 < 65535) ref_c0++;
        if (sp == 1 && ref_c1 < 65535) ref_c1++;
        if (!inr && ref_ce < 65535) ref_ce++;
        ref_last = sp;
      end else begin
        chk1("post_ocupado", ocupado, 1'b0);
        chk1("post_ack", ack0 | ack1, 1'b0);
`ifdef MEM_ARB_CONTADOR_EN
        chk("cont0", 32'(cont0), 32'(ref_c0));
        chk("cont1", 32'(cont1), 32'(ref_c1));
        chk("cont_err", 32'(cont_err), 32'(ref_ce));
`endif
        if (sp == 0) begin
          void'(q0.pop_front());
          if (q0.size() > 0) drive(0, 1'b1, q0[0]); else req0 = 1'b0;
        end else begin
          void'(q1.pop_front());
          if (q1.size() > 0) drive(1, 1'b1, q1[0]); else req1 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n0, n1;
    logic [31:0] d7;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1;
    drive(0, 1'b0, mk(1'b0, 32'd0, 32'd0));
    drive(1, 1'b0, mk(1'b0, 32'd0, 32'd0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ocupado", ocupado, 1'b0);
    chk1("rst_ack", ack0 | ack1 | err0 | err1, 1'b0);
    chk1("rst_strobes", memWrite | memRead, 1'b0);
    chk("rst_posicao", posicao, 32'd0);
    chk("rst_dados", dados, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    rst = 1'b0;
    idle(2);

    // Port 0 write, then port 1 reads it back.
    q0.push_back(mk(1'b1, 32'd5, 32'hDEAD_BEEF));
    run_batch();
    q1.push_back(mk(1'b0, 32'd5, 32'd0));
    run_batch();
    chk("readback5", ref_rd[1], 32'hDEAD_BEEF);

    // Simultaneous requests right after reset: port 0 first, then strict alternation.
    do_reset();
    q0.push_back(mk(1'b1, 32'd10, 32'h1111_0000));
    q0.push_back(mk(1'b0, 32'd11, 32'd0));
    q1.push_back(mk(1'b0, 32'd10, 32'd0));
    q1.push_back(mk(1'b1, 32'd11, 32'h2222_0000));
    run_batch();

    // Out-of-range write must not touch word 0 (or any aliased word).
    q0.push_back(mk(1'b1, 32'd64, 32'hBAD0_BAD0));
    run_batch();
    q1.push_back(mk(1'b0, 32'd0, 32'd0));
    q0.push_back(mk(1'b0, 32'h0000_0100, 32'd0));
    run_batch();
    chk("word0_kept", mem[0], ref_mem[0]);

    // Reset during the access cycle of a write to word 7.
    d7 = $urandom;
    drive(0, 1'b1, mk(1'b1, 32'd7, d7));
    @(posedge clk); #1;
    chk1("mid_memWrite", memWrite, 1'b1);
    chk("mid_posicao", posicao, 32'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b0;
    model_reset();
    ref_mem[7] = d7;
    chk1("midrst_ocupado", ocupado, 1'b0);
    chk1("midrst_ack", ack0 | ack1 | err0 | err1, 1'b0);
    chk1("midrst_strobes", memWrite | memRead, 1'b0);
    chk("midrst_posicao", posicao, 32'd0);
    chk("midrst_dados", dados, 32'd0);
    chk("word7", mem[7], d7);
    idle(2);
    q1.push_back(mk(1'b0, 32'd7, 32'd0));
    run_batch();

    // Random batches with random idle gaps.
    for (int it = 0; it < 40; it++) begin
      q0.delete(); q1.delete();
      n0 = $urandom_range(0, 3);
      n1 = (n0 == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      for (int j = 0; j < n0; j++) q0.push_back(rnd_txn());
      for (int j = 0; j < n1; j++) q1.push_back(rnd_txn());
      run_batch();
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitro_mem_dados.md
Name: arbitro_mem_dados

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (64 x 32-bit, synchronous write, combinational read).
- Port 0 is the CPU load/store path; port 1 is a secondary master (loader/debug).
- Grants one access at a time with round-robin fairness, latches the request, and drives the memory write/read controls for exactly one cycle.
- Returns read data with a registered ack pulse and flags out-of-range addresses.

Parameters:
DATA_W, 32, data width of the memory word
ADDR_W, 32, width of requester addresses and of posicao
DEPTH, 64, number of memory words; addresses >= DEPTH are out of range

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  port 0 request; held high with we0/addr0/wdata0 stable until ack0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse, one cycle
rdata0  out  DATA_W  port 0 read data, valid while ack0 = 1
err0  out  1  port 0 out-of-range flag, valid while ack0 = 1
req1, we1, addr1, wdata1, ack1, rdata1, err1  same as port 0, for port 1
posicao  out  ADDR_W  memory address
dados  out  DATA_W  memory write data
memWrite  out  1  memory write enable
memRead  out  1  memory read strobe
saidaDados  in  DATA_W  memory combinational read data
ocupado  out  1  high in any state other than OCIOSO

Behaviour:
- Reset (rst high at a clk edge):
  - state = OCIOSO; all ack/err/memWrite/memRead = 0; rdata0/rdata1/posicao/dados = 0.
  - Round-robin pointer ultimo = 1, so port 0 wins the first tie.
  - Reset mid-access aborts the access: no ack, and no memWrite in the following cycle.
- FSM states: OCIOSO -> ACESSO -> RESP -> OCIOSO.
- OCIOSO:
  - No req: stay.
  - One req: grant that port.
  - Both req: grant the port != ultimo.
  - On grant: register sel, we, addr, wdata; set ultimo = sel; go ACESSO.
- ACESSO (exactly 1 cycle):
  - posicao = latched addr.
  - If addr < DEPTH: memWrite = we, memRead = ~we.
  - If addr >= DEPTH: memWrite = 0, memRead = 0, and err is latched.
  - dados = latched wdata.
  - For a read, saidaDados is captured into the selected rdata register at the end of the cycle; for out-of-range, 0 is captured.
  - Go RESP.
- RESP (1 cycle):
  - ack_sel = 1 and err_sel = latched err; memWrite/memRead = 0.
  - The unselected port's ack/err = 0.
  - For a write, the selected rdata holds its previous value.
  - Go OCIOSO.
- Handshake:
  - The requester deasserts req on the clk edge that samples ack high.
  - req still high in the cycle after ack counts as a new request.
- Latency:
  - Request seen at edge N, ack high in cycle N+2.
  - Minimum 3 cycles per access; back-to-back throughput is 1 access per 3 cycles.
- Fairness: with both req held continuously, grants alternate 0,1,0,1…; no port waits more than one other access.
- Requests arriving while ocupado = 1 wait; they are evaluated only in OCIOSO.
- Memory outputs are registered or decoded from registered state only; no combinational path from req/addr to memWrite.
- Address compare uses the full ADDR_W bits; no wrap-around or truncation.

Optional Feature:
- Macro: MEM_ARB_CONTADOR_EN
- Defined:
  - Adds outputs cont0 and cont1 (16 bits each): saturating counts of completed acks per port (stop at 16'hFFFF).
  - Adds output cont_err (16 bits): saturating count of out-of-range accesses.
  - All three reset to 0; each increments in the RESP cycle.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then port 0 writes addr 5 / data 32'hDEADBEEF -> memWrite = 1 only in ACESSO cycle with posicao = 5; ack0 two cycles after request, err0 = 0.
- Port 1 reads addr 5 after the above -> memRead = 1 in ACESSO; ack1 with rdata1 = 32'hDEADBEEF; ack0 stays 0.
- req0 and req1 rise in the same cycle after reset, both held for 4 accesses -> grant order 0,1,0,1; each ack is spaced 3 cycles apart.
- Port 0 write to addr 64 -> memWrite never asserts; ack0 = 1 with err0 = 1; memory word 0 is unchanged.
- rst asserted during ACESSO of a write to addr 7 -> next cycle state = OCIOSO with all outputs 0 and no ack; word 7 content is defined only by the write cycle already elapsed.
- With MEM_ARB_CONTADOR_EN: 3 port-0 accesses, 2 port-1 accesses and 1 out-of-range -> cont0 = 3 (includes the out-of-range access if it was on port 0), cont1 = 2, cont_err = 1.
